// File: rtl/sfu_pre_processor_pipe.sv
// SFU pre-processor pipeline.
// Decomposes each FP32 lane into sign, exponent, table index and interpolation
// offset, issues the coefficient ROM read and registers c0/c1/c2, y and the
// special-case bypass value for the polynomial evaluator. The pipeline has two
// stages (S1 + output register) and freezes globally while the output is stalled.
module sfu_pre_processor_pipe #(
  parameter int LANES    = 1,
  parameter int IDX_BITS = 7,
  parameter int C0_W     = 29,
  parameter int C1_W     = 25,
  parameter int C2_W     = 17,
  parameter int TAG_W    = 4,
  localparam int AW      = 3 + IDX_BITS,
  localparam int Y_W     = 24 - IDX_BITS,
  localparam int CW      = C0_W + C1_W + C2_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_opcode,
  input  logic [32*LANES-1:0]     in_x,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    rom_en,
  output logic [AW*LANES-1:0]     rom_addr,
  input  logic [CW*LANES-1:0]     rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_sign,
  output logic [9*LANES-1:0]      out_exponent,
  output logic [LANES-1:0]        out_skip,
  output logic [32*LANES-1:0]     out_skip_val,
  output logic [C0_W*LANES-1:0]   out_c0,
  output logic [C1_W*LANES-1:0]   out_c1,
  output logic [C2_W*LANES-1:0]   out_c2,
  output logic [Y_W*LANES-1:0]    out_y,
  output logic [TAG_W-1:0]        out_tag
);

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic           sign;
    logic [8:0]     exponent;
    logic [Y_W-1:0] y;
    logic           skip;
    logic [31:0]    skip_val;
  } lane_t;

  // Per-lane decomposition and special-case classification of one operand.
  function automatic lane_t decode(input logic [3:0] op, input logic [31:0] x);
    lane_t                d;
    logic [7:0]           e;
    logic [22:0]          m;
    logic [8:0]           ue;
    logic [IDX_BITS-1:0]  idx;
    logic                 zero;
    logic                 inf;
    logic                 nan;
    logic                 legal;
    e     = x[30:23];
    m     = x[22:0];
    ue    = {1'b0, e} - 9'd127;
    zero  = (e == 8'd0);
    inf   = (e == 8'hFF) && (m == 23'd0);
    nan   = (e == 8'hFF) && (m != 23'd0);
    legal = (op <= 4'd3) || (op == 4'd8);
    d      = '0;
    d.sign = x[31];
    case (op)
      4'd0, 4'd3: begin
        idx        = m[22 -: IDX_BITS];
        d.y        = {m[22-IDX_BITS:0], 1'b0};
        d.exponent = ue;
      end
      4'd1, 4'd2: begin
        // Exponent parity selects the half-table so odd exponents fold into the mantissa range.
        idx        = {ue[0], m[22 -: IDX_BITS-1]};
        d.y        = m[23-IDX_BITS:0];
        d.exponent = {ue[8], ue[8:1]};
      end
      default: begin
        idx        = '0;
        d.exponent = ue;
      end
    endcase
    d.addr = {op[2:0], idx};
    d.skip = 1'b1;
    if (nan) begin
      d.skip_val = 32'h7FC00000;
    end else if (!legal) begin
      d.skip_val = 32'h7FC00000;
    end else if (op == 4'd8) begin
      if (x[31] || zero) begin
        d.skip_val = 32'h00000000;
      end else if (x[30:0] >= 31'h40C00000) begin
        d.skip_val = 32'h40C00000;
      end else begin
        d.skip_val = x;
      end
    end else if (x[31] && !zero && (op != 4'd0)) begin
      d.skip_val = 32'h7FC00000;
    end else if (zero) begin
      case (op)
        4'd0:    d.skip_val = {x[31], 31'h7F800000};
        4'd1:    d.skip_val = 32'h7F800000;
        4'd2:    d.skip_val = x;
        default: d.skip_val = 32'hFF800000;
      endcase
    end else if (inf && !x[31]) begin
      case (op)
        4'd0, 4'd1: d.skip_val = 32'h00000000;
        default:    d.skip_val = 32'h7F800000;
      endcase
    end else if (inf) begin
      d.skip_val = 32'h80000000;
    end else begin
      d.skip     = 1'b0;
      d.skip_val = 32'h00000000;
    end
    if (d.skip) begin
      d.y = '0;
    end else begin
      d.y = d.y;
    end
    return d;
  endfunction

  logic               stall_s;
  lane_t [LANES-1:0]  dec_s;
  lane_t [LANES-1:0]  s1_lane_r;
  logic               s1_valid_r;
  logic [TAG_W-1:0]   s1_tag_r;

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;
  assign rom_en   = in_valid & in_ready;

  // Decode every lane of the incoming operand and drive the ROM address.
  always_comb begin
    dec_s    = '0;
    rom_addr = '0;
    for (int i = 0; i < LANES; i++) begin
      dec_s[i]              = decode(in_opcode, in_x[32*i +: 32]);
      rom_addr[AW*i +: AW]  = dec_s[i].addr;
    end
  end

  // S1: hold the decoded lanes while the ROM word for them is being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_tag_r   <= '0;
      s1_lane_r  <= '0;
    end else if (!stall_s) begin
      s1_valid_r <= in_valid;
      s1_tag_r   <= in_tag;
      s1_lane_r  <= dec_s;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Output register: merge S1 fields with the ROM coefficients, zeroed for bypassed lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_tag      <= '0;
      out_sign     <= '0;
      out_exponent <= '0;
      out_skip     <= '0;
      out_skip_val <= '0;
      out_c0       <= '0;
      out_c1       <= '0;
      out_c2       <= '0;
      out_y        <= '0;
    end else if (!stall_s) begin
      out_valid <= s1_valid_r;
      out_tag   <= s1_tag_r;
      for (int i = 0; i < LANES; i++) begin
        out_sign[i]                 <= s1_lane_r[i].sign;
        out_exponent[9*i +: 9]      <= s1_lane_r[i].exponent;
        out_skip[i]                 <= s1_lane_r[i].skip;
        out_skip_val[32*i +: 32]    <= s1_lane_r[i].skip_val;
        out_y[Y_W*i +: Y_W]         <= s1_lane_r[i].y;
        if (s1_lane_r[i].skip) begin
          out_c0[C0_W*i +: C0_W] <= '0;
          out_c1[C1_W*i +: C1_W] <= '0;
          out_c2[C2_W*i +: C2_W] <= '0;
        end else begin
          out_c0[C0_W*i +: C0_W] <= rom_data[CW*i + C1_W + C2_W +: C0_W];
          out_c1[C1_W*i +: C1_W] <= rom_data[CW*i + C2_W +: C1_W];
          out_c2[C2_W*i +: C2_W] <= rom_data[CW*i +: C2_W];
        end
      end
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_sfu_pre_processor_pipe.sv
// Scoreboard bench for sfu_pre_processor_pipe with two lanes and a model ROM.
module tb_sfu_pre_processor_pipe;

  localparam int L = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_opcode = 4'd0;
  logic [63:0]   in_x = 64'd0;
  logic [3:0]    in_tag = 4'd0;
  logic          rom_en;
  logic [19:0]   rom_addr;
  logic [141:0]  rom_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    out_sign;
  logic [17:0]   out_exponent;
  logic [1:0]    out_skip;
  logic [63:0]   out_skip_val;
  logic [57:0]   out_c0;
  logic [49:0]   out_c1;
  logic [33:0]   out_c2;
  logic [33:0]   out_y;
  logic [3:0]    out_tag;

  int checks = 0;
  int errors = 0;
  bit bp_rand = 1'b0;

  typedef struct {
    logic [1:0]  sign;
    logic [17:0] ex;
    logic [1:0]  skip;
    logic [63:0] sv;
    logic [57:0] c0;
    logic [49:0] c1;
    logic [33:0] c2;
    logic [33:0] y;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb_q[$];

  sfu_pre_processor_pipe #(.LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_x(in_x), .in_tag(in_tag), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sign(out_sign), .out_exponent(out_exponent),
    .out_skip(out_skip), .out_skip_val(out_skip_val), .out_c0(out_c0),
    .out_c1(out_c1), .out_c2(out_c2), .out_y(out_y), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] rom_word(input logic [9:0] a);
    logic [28:0] c0;
    logic [24:0] c1;
    logic [16:0] c2;
    c0 = 29'(int'(a) * 7919 + 12345);
    c1 = 25'(int'(a) * 104729) ^ 25'h155555;
    c2 = {a[6:0], a} ^ 17'h0ABCD;
    return {c0, c1, c2};
  endfunction

  // Behavioural reference for one lane, straight from the arithmetic rules.
  function automatic void model(input logic [3:0] op, input logic [31:0] x,
      output logic [9:0] addr, output logic sign, output logic [8:0] ex,
      output logic [16:0] y, output logic skip, output logic [31:0] sv,
      output logic [28:0] c0, output logic [24:0] c1, output logic [16:0] c2);
    int e, m, ue, idx, yv, expi;
    bit zero, inf, nan, neg, legal;
    logic [70:0] w;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    ue = e - 127;
    neg = x[31];
    zero = (e == 0);
    inf = (e == 255) && (m == 0);
    nan = (e == 255) && (m != 0);
    legal = (op <= 4'd3) || (op == 4'd8);
    if (op == 4'd0 || op == 4'd3) begin
      idx = m / 65536; yv = (m % 65536) * 2; expi = ue;
    end else if (op == 4'd1 || op == 4'd2) begin
      idx = (ue & 1) * 64 + m / 131072; yv = m % 131072; expi = (ue - (ue & 1)) / 2;
    end else begin
      idx = 0; yv = 0; expi = ue;
    end
    addr = 10'((int'(op) % 8) * 128 + idx);
    sign = neg;
    ex = 9'(expi);
    skip = 1'b1;
    if (nan || !legal) sv = 32'h7FC00000;
    else if (op == 4'd8) sv = (neg || zero) ? 32'h0 : (x >= 32'h40C00000 ? 32'h40C00000 : x);
    else if (neg && !zero && op != 4'd0) sv = 32'h7FC00000;
    else if (zero) sv = (op == 4'd0) ? (neg ? 32'hFF800000 : 32'h7F800000) :
                        (op == 4'd1) ? 32'h7F800000 : (op == 4'd2) ? x : 32'hFF800000;
    else if (inf && !neg) sv = (op <= 4'd1) ? 32'h0 : 32'h7F800000;
    else if (inf) sv = 32'h80000000;
    else begin skip = 1'b0; sv = 32'h0; end
    w = rom_word(addr);
    y  = skip ? 17'd0 : 17'(yv);
    c0 = skip ? 29'd0 : w[70:42];
    c1 = skip ? 25'd0 : w[41:17];
    c2 = skip ? 17'd0 : w[16:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Model ROM: registered read on rom_en, holds its word otherwise.
  initial forever begin
    @(posedge clk);
    if (rom_en) rom_data <= {rom_word(rom_addr[19:10]), rom_word(rom_addr[9:0])};
  end

  // Random backpressure generator.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: push expectations on accept, pop and compare on output transfer.
  initial begin
    exp_t e, h;
    bit held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        held = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_outputs", {out_tag, out_skip, out_skip_val[31:0]}, 64'd0);
        chk("reset_coef", 64'(out_c0 | 58'(out_y)), 64'd0);
      end else begin
        if (held) begin
          chk("stall_hold_valid", 64'(out_valid), 64'd1);
          chk("stall_hold_data", {out_tag, out_skip_val[59:0]}, {h.tag, h.sv[59:0]});
        end
        held = 1'b0;
        if (in_valid && in_ready) begin
          for (int i = 0; i < L; i++) begin
            logic [9:0] a; logic s; logic [8:0] x9; logic [16:0] y; logic sk;
            logic [31:0] sv; logic [28:0] c0; logic [24:0] c1; logic [16:0] c2;
            model(in_opcode, in_x[32*i +: 32], a, s, x9, y, sk, sv, c0, c1, c2);
            chk($sformatf("rom_addr_l%0d", i), 64'(rom_addr[10*i +: 10]), 64'(a));
            e.sign[i] = s; e.ex[9*i +: 9] = x9; e.skip[i] = sk; e.sv[32*i +: 32] = sv;
            e.c0[29*i +: 29] = c0; e.c1[25*i +: 25] = c1; e.c2[17*i +: 17] = c2;
            e.y[17*i +: 17] = y;
          end
          e.tag = in_tag;
          chk("rom_en", 64'(rom_en), 64'd1);
          sb_q.push_back(e);
        end else begin
          chk("rom_en_idle", 64'(rom_en), 64'd0);
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 64'(out_tag), 64'hDEAD);
          end else if (out_ready) begin
            e = sb_q.pop_front();
            chk("tag", 64'(out_tag), 64'(e.tag));
            chk("sign_exp_skip", {out_sign, out_exponent, out_skip}, {e.sign, e.ex, e.skip});
            chk("skip_val", out_skip_val, e.sv);
            chk("c0", 64'(out_c0), 64'(e.c0));
            chk("c1_c2", {out_c1[29:0], out_c2}, {e.c1[29:0], e.c2});
            chk("y", 64'(out_y), 64'(e.y));
          end else begin
            held = 1'b1;
            h.tag = out_tag;
            h.sv = out_skip_val;
          end
        end
      end
    end
  end

  // Drive one transaction and wait (bounded) for it to be accepted.
  task automatic send(input logic [3:0] op, input logic [63:0] x, input logic [3:0] tag,
                      input int ea0, input int ea1);
    int n = 0;
    in_valid = 1'b1; in_opcode = op; in_x = x; in_tag = tag;
    #1;
    if (ea0 >= 0) chk("direct_addr_l0", 64'(rom_addr[9:0]), 64'(ea0));
    if (ea1 >= 0) chk("direct_addr_l1", 64'(rom_addr[19:10]), 64'(ea1));
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_x();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0: return {r[31], 31'd0};
      1: return {r[31], 8'hFF, 23'd0};
      2: return {r[31], 8'hFF, r[22:0] | 23'd1};
      3: return {1'b0, 8'($urandom_range(120, 131)), r[22:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [3:0] op;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(4'd0, {32'h3F800000, 32'h3FC00000}, 4'd3, 32'h040, 32'h000);
    send(4'd1, {32'h40000000, 32'h40800000}, 4'd4, 32'h080, 32'h0C0);
    send(4'd1, {32'h40800000, 32'h40000000}, 4'd5, 32'h0C0, 32'h080);
    send(4'd2, {32'h40800000, 32'hBF800000}, 4'd6, -1, -1);
    send(4'd8, {32'hC0000000, 32'h41000000}, 4'd7, 32'h000, 32'h000);
    send(4'd0, {32'h7F800000, 32'h80000000}, 4'd8, -1, -1);
    send(4'd5, {32'h3F800000, 32'h3F800000}, 4'd9, 32'h280, 32'h280);
    send(4'd0, {32'h40800000, 32'h3FC00000}, 4'd10, 32'h040, 32'h000);
    send(4'd0, {32'h7FC00001, 32'h3FC00000}, 4'd11, 32'h040, -1);
    send(4'd3, {32'h00000000, 32'hFF800000}, 4'd12, -1, -1);

    // Backpressure: four back-to-back items while the output is held off.
    repeat (3) @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 4; t++) send(4'd0, {$urandom, 32'h3FC00000}, 4'(t), -1, -1);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Reset with two items in flight, then exact-latency check on a fresh item.
    send(4'd0, {32'h40400000, 32'h40400000}, 4'd1, -1, -1);
    send(4'd3, {32'h40400000, 32'h40400000}, 4'd2, -1, -1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    send(4'd1, {32'h3F800000, 32'h41100000}, 4'd13, -1, -1);
    @(negedge clk);
    chk("latency_not_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_two", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Randomised traffic with random backpressure.
    bp_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 6))
        0: op = 4'd0;
        1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'd3;
        4: op = 4'd8;
        5: op = 4'($urandom_range(0, 15));
        default: op = 4'd0;
      endcase
      send(op, {rand_x(), rand_x()}, 4'($urandom), -1, -1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    bp_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int w = 0; w < 50 && sb_q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    chk("drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfu_pre_processor_pipe.md
# sfu_pre_processor_pipe

Pipelined, multi-lane successor to the SFU pre-processor. Accepts FP32 operands under a valid/ready handshake and decomposes each lane into sign, exponent, table index and interpolation offset. It issues a synchronous coefficient-ROM read and delivers registered c0/c1/c2, y and special-case bypass results to the second-order polynomial datapath. Sits between the SFU issue queue and the multiply-add evaluator.

## Interface
- LANES, 1: independent FP32 lanes sharing one opcode
- IDX_BITS, 7: table-index width per opcode
- C0_W, 29 / C1_W, 25 / C2_W, 17: coefficient widths
- TAG_W, 4: pass-through tag width
- Derived: AW = 3+IDX_BITS (ROM address); Y_W = 24-IDX_BITS; CW = C0_W+C1_W+C2_W
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- in_valid / in_ready  in / out  1  input handshake
- in_opcode  in  4  0=RCP, 1=RSQ, 2=SQRT, 3=LOG2, 8=RELU6, others illegal
- in_x  in  32*LANES  operands, lane i at [32i+31:32i]
- in_tag  in  TAG_W  returned unchanged with the result
- rom_en  out  1  ROM read strobe
- rom_addr  out  AW*LANES  per-lane ROM address
- rom_data  in  CW*LANES  per-lane {c0,c1,c2}; valid 1 cycle after rom_en; ROM holds output while rom_en=0
- out_valid / out_ready  out / in  1  output handshake
- out_sign  out  LANES  per-lane sign
- out_exponent  out  9*LANES  signed exponent
- out_skip  out  LANES  lane bypasses the evaluator
- out_skip_val  out  32*LANES  FP32 bypass result
- out_c0 / out_c1 / out_c2  out  C0_W/C1_W/C2_W per lane  coefficients
- out_y  out  Y_W*LANES  unsigned interpolation offset
- out_tag  out  TAG_W

## Operation
- Per lane: s=x[31]; E=x[30:23]; m=x[22:0]; ue=E-127 (signed 9 bit). E=0 is treated as zero (denormals flushed).
- RCP, LOG2: idx=m[22:23-IDX_BITS]; y={m[22-IDX_BITS:0],1'b0}; exponent=ue.
- RSQ, SQRT: idx={ue[0], m[22:24-IDX_BITS]}; y=m[23-IDX_BITS:0]; exponent=ue>>>1 (arithmetic).
- rom_addr = {opcode[2:0], idx}. RELU6 and illegal opcodes use idx=0.
- Skip cases, first match wins:
  - NaN input -> 7FC00000.
  - Illegal opcode -> 7FC00000.
  - RELU6 always skips: val = x≤0 (incl. -0) -> 00000000; x≥6.0 -> 40C00000; else x.
  - Negative nonzero for RSQ/SQRT/LOG2 -> 7FC00000.
  - Zero: RCP -> ±inf (sign kept); RSQ -> 7F800000; SQRT -> x; LOG2 -> FF800000.
  - +inf: RCP -> +0; RSQ -> 0; SQRT/LOG2 -> 7F800000.
  - -inf: RCP -> 80000000.
- Skipped lanes: c0/c1/c2/y forced 0; sign/exponent still reported.
- Non-skipped lanes: skip_val = 0.
- Stall definition: stall = out_valid & ~out_ready.
- in_ready = ~stall.
- rom_en = in_valid & in_ready.

## Timing
- Pipeline stages: accept in cycle T (rom_addr combinational from in_x); S1 register at edge T+1 with ROM data valid during T+1; output register at edge T+2. out_valid high from cycle T+2. Latency 2.
- Throughput: 1 operation per cycle with out_ready=1.
- During stall, all stages and rom_en freeze. The ROM data held by the ROM stays aligned with S1. No bubbles are squeezed.
- Order is strictly preserved. Output is stable while out_valid & ~out_ready.
- An S1 bubble (S1 empty) may advance into the output register during a stall only if the output register is empty. The simple global freeze is acceptable and required.
- Reset: out_valid=0, all out_* = 0, S1 valid=0. Reset mid-operation discards in-flight items, with no output on the first cycle after release. in_ready=1 during and after reset.
- in_valid while in_ready=0: input ignored, must be held by the source.

## Test plan
- RCP x=3FC00000 (1.5), tag 3 -> rom_addr=0x040, 2 cycles later out_exponent=0, out_y=0, out_skip=0, coefficients equal to the model ROM word at 0x040, out_tag=3.
- RSQ x=40800000 (4.0) -> rom_addr=0x080, exponent=1; RSQ x=40000000 (2.0) -> rom_addr=0x0C0, exponent=0; both back-to-back, one output per cycle.
- Specials:
  - SQRT BF800000 -> skip, 7FC00000.
  - RELU6 41000000 -> 40C00000.
  - RELU6 C0000000 -> 00000000.
  - RCP 80000000 -> FF800000.
  - opcode 5 -> 7FC00000.
- Backpressure: 4 back-to-back inputs with tags 0..3 and out_ready=0 for 3 cycles -> in_ready low while stalled, outputs tagged 0,1,2,3 in order, none dropped or duplicated.
- Reset: assert rst_n=0 with 2 items in flight -> out_valid=0 next cycle, no stale output after release; a new input produces output exactly 2 cycles after acceptance.
- LANES=2, in_x={40800000, 3FC00000}, opcode RCP -> lane0 addr 0x040, lane1 addr 0x000, independent coefficients; a lane-1 NaN skips only lane 1.
